// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file:
// default geometry, the byte-merge rule and flattened read-port indexing.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // One byte lane of a byte-enabled write: the enabled lane takes the new byte.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

    // Low bit of field 'port' inside a flattened bus of 'width'-bit fields.
    function automatic int rd_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: reservation handshake from decode,
// release on writeback, hazard flags for each read port and a live busy count.
module reg_file_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic                     rsv_ready,
    output logic [NUM_RD-1:0]        read_busy,
    output logic [ADDR_W:0]          busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy;
    logic             zero_rsv;
    logic             wb_hits_rsv;
    logic             accept;
    logic             wb_release;

    assign zero_rsv    = (ZERO_REG != 0) && (rsv_addr == '0);
    assign wb_hits_rsv = reg_write && (write_addr == rsv_addr);

    // A writeback in the same cycle frees the register for immediate re-reservation.
    assign rsv_ready  = !rst && (zero_rsv || !busy[rsv_addr] || wb_hits_rsv);
    assign accept     = rsv_valid && rsv_ready && !zero_rsv;
    assign wb_release = reg_write && busy[write_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            // Set after clear so a same-register release+reserve leaves the bit at 1.
            if (wb_release) busy[write_addr] <= 1'b0;
            if (accept)     busy[rsv_addr]   <= 1'b1;
            if (accept && !wb_release)
                busy_count <= busy_count + (ADDR_W+1)'(1);
            else if (wb_release && !accept)
                busy_count <= busy_count - (ADDR_W+1)'(1);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
        localparam int LO = rd_lo(k, ADDR_W);
        logic [ADDR_W-1:0] ra;
        assign ra           = read_addr[LO +: ADDR_W];
        assign read_busy[k] = !rst && busy[ra] && !(reg_write && (write_addr == ra));
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with byte-enable writes, write-to-read bypass
// and a busy scoreboard for RAW/WAW hazard detection in a pipelined core.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [DATA_W/8-1:0]      write_be,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ready,
    output logic [ADDR_W:0]          busy_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] merged;
    logic              wr_en;

    // The merged word is both the value stored and the value bypassed to readers.
    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = byte_merge(regs[write_addr][8*i +: 8],
                                          write_data[8*i +: 8], write_be[i]);
    end

    assign wr_en = reg_write && !((ZERO_REG != 0) && (write_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else if (wr_en) begin
            regs[write_addr] <= merged;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int ALO = rd_lo(k, ADDR_W);
        localparam int DLO = rd_lo(k, DATA_W);
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              bypass;
        assign ra      = read_addr[ALO +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign bypass  = reg_write && (write_addr == ra);
        assign read_data[DLO +: DATA_W] = (rst || is_zero) ? '0 :
                                          bypass           ? merged : regs[ra];
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .read_addr  (read_addr),
        .rsv_ready  (rsv_ready),
        .read_busy  (read_busy),
        .busy_count (busy_count)
    );

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the single-cycle CPU register file. Adds a configurable number of read ports, byte-enable writes, same-cycle write-to-read bypass, and a per-register busy scoreboard with a reservation handshake, so a pipelined core can detect RAW/WAW hazards. Sits between the decode stage (reads, reservations) and the writeback stage (writes, busy release).

## Interface

Parameters:
- DATA_W, 32, register width; must be a multiple of 8
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and reservations

Ports:
- clk  in  1  rising-edge clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- reg_write  in  1  writeback strobe
- write_addr  in  ADDR_W  writeback register
- write_data  in  DATA_W  writeback data
- write_be  in  DATA_W/8  byte enables; bit i covers bits 8i+7:8i
- read_addr  in  NUM_RD*ADDR_W  flattened read addresses; port k at bits k*ADDR_W+:ADDR_W
- read_data  out  NUM_RD*DATA_W  flattened read data; combinational
- read_busy  out  NUM_RD  scoreboard bit of each addressed register, after bypass
- rsv_valid  in  1  decode requests reservation of rsv_addr
- rsv_addr  in  ADDR_W  destination to reserve
- rsv_ready  out  1  reservation can be accepted this cycle
- busy_count  out  ADDR_W+1  number of registers currently busy

## Operation

- Write: on a clk edge with reg_write=1 and no rst, each byte i with write_be[i]=1 is updated; other bytes keep their value. When ZERO_REG=1 and write_addr=0, nothing is written.
- Read: read_data[k] = stored value of read_addr[k]. When reg_write=1 and write_addr==read_addr[k] (non-zero if ZERO_REG), the bypass value is returned: enabled bytes from write_data, other bytes from storage. Register 0 always returns 0 when ZERO_REG=1.
- Scoreboard: busy[r] is set on acceptance (rsv_valid && rsv_ready) and cleared by any reg_write to r, regardless of write_be.
- rsv_ready = !busy[rsv_addr] || (reg_write && write_addr==rsv_addr). Reserving register 0 with ZERO_REG=1: rsv_ready=1, no bit is set.
- Same-cycle writeback and reservation of the same register: the writeback release and the new reservation combine, busy stays 1, busy_count is unchanged.
- read_busy[k] = busy[read_addr[k]] && !(reg_write && write_addr==read_addr[k]). A same-cycle reservation does not affect read_busy until the next cycle.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- busy_count is incremented on acceptance of a new bit and decremented on a release. Both in one cycle on different registers leaves it net 0. It never exceeds 2**ADDR_W - ZERO_REG.

## Timing

- Reads, read_busy and rsv_ready are combinational: 0-cycle latency, bypass included.
- Write data, busy bits and busy_count all update at the clk edge.
- Reset: at the first edge with rst=1, all registers become 0, all busy bits 0, and busy_count 0. While rst=1, read_data is forced to 0, read_busy to 0 and rsv_ready to 0. Writes and reservations presented with rst=1 are dropped.
- A reset mid-operation discards every outstanding reservation. A writeback arriving later for a dropped reservation is a plain write.

## Structure

- Package rf_pkg holds: default DATA_W/ADDR_W/NUM_RD constants, the byte-merge function (old, new, be), and the index helpers for the flattened read ports.
- Sub-module reg_file_scoreboard holds busy bits, rsv_ready, read_busy and busy_count. The top level holds storage, bypass and the read muxes in a generate loop over NUM_RD.

## Test plan

- Reset then zero register: rst 1 cycle, then write r0=32'hFFFF_FFFF with be=4'hF. Next cycle, read r0 on both ports gives 0 and busy_count=0.
- Byte enables and bypass: r31=32'hFFFF_FFFF, then write r31=32'h1234_5678 with be=4'b0101. In that same cycle read_data shows 32'hFF34_FF78, and after the edge storage holds 32'hFF34_FF78.
- Read-only cycle: reg_write=0 with write_addr=16 and data 32'h8888_8888. r16 reads 0; r15 reads 0.
- Reservation flow: reserve r30, then next cycle rsv_ready=0 for r30, read_busy=1 on a port reading r30, and busy_count=1. Writeback r30=32'h7777_7777: same cycle read_busy=0 and data=32'h7777_7777; next cycle busy_count=0.
- Simultaneous: r5 busy; writeback r5 and reserve r5 in the same cycle. rsv_ready=1, busy[5] stays 1, busy_count stays 1. Also reserve r0 gives rsv_ready=1 and busy_count unchanged.
- Reset mid-flight: reserve r1, r2, r3 (busy_count=3), then assert rst. Next cycle busy_count=0, all reads 0, and a later writeback to r2 leaves busy_count at 0.
